// File: rtl/cmd_byte_assembler.sv
// Glue between the UART and the command processor: packs two received bytes into a
// 16-bit command and forwards 1-byte responses to the transmitter with a 1-deep backlog.
module cmd_byte_assembler #(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        ovr_err,
  output logic        to_err,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_sent
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {RX_HIGH, RX_LOW} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [7:0]       hi_byte_q, hi_byte_d;
  logic [15:0]      cmd_q, cmd_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             ovr_err_q, ovr_err_d;
  logic             to_err_q, to_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  tx_state_t        tx_state_q, tx_state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             trmt_q, trmt_d;
  logic             resp_sent_q, resp_sent_d;
  logic             pend_q, pend_d;
  logic [7:0]       pend_data_q, pend_data_d;

  // Every byte offered is consumed immediately, whichever half of the command it is.
  assign clr_rx_rdy = rx_rdy & rst_n;

  always_comb begin
    rx_state_d = rx_state_q;
    hi_byte_d  = hi_byte_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q & ~clr_cmd_rdy;
    cnt_d      = cnt_q;
    ovr_err_d  = 1'b0;
    to_err_d   = 1'b0;
    case (rx_state_q)
      RX_HIGH: begin
        if (rx_rdy) begin
          hi_byte_d  = rx_data;
          cmd_rdy_d  = 1'b0;
          cnt_d      = '0;
          rx_state_d = RX_LOW;
        end
      end
      RX_LOW: begin
        if (rx_rdy) begin
          cmd_d      = {hi_byte_q, rx_data};
          cmd_rdy_d  = 1'b1;
          ovr_err_d  = cmd_rdy_q & ~clr_cmd_rdy;
          rx_state_d = RX_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          to_err_d   = 1'b1;
          hi_byte_d  = '0;
          cnt_d      = '0;
          rx_state_d = RX_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_HIGH;
    endcase
  end

  // A response arriving together with tx_done jumps ahead of (and replaces) any backlog.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_d  = resp;
          trmt_d     = 1'b1;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          resp_sent_d = 1'b1;
          pend_d      = 1'b0;
          if (send_resp) begin
            tx_data_d = resp;
            trmt_d    = 1'b1;
          end else if (pend_q) begin
            tx_data_d = pend_data_q;
            trmt_d    = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else if (send_resp) begin
          pend_d      = 1'b1;
          pend_data_d = resp;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q  <= RX_HIGH;
      hi_byte_q   <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      ovr_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
      cnt_q       <= '0;
      tx_state_q  <= TX_IDLE;
      tx_data_q   <= '0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      rx_state_q  <= rx_state_d;
      hi_byte_q   <= hi_byte_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      ovr_err_q   <= ovr_err_d;
      to_err_q    <= to_err_d;
      cnt_q       <= cnt_d;
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      trmt_q      <= trmt_d;
      resp_sent_q <= resp_sent_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign ovr_err   = ovr_err_q;
  assign to_err    = to_err_q;
  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_cmd_byte_assembler.sv
// Bench for cmd_byte_assembler: directed scenarios followed by random traffic, all checked
// against a timestamp/queue model of the command and response rules.
module tb_cmd_byte_assembler;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        ovr_err;
  logic        to_err;
  logic        send_resp;
  logic [7:0]  resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;

  int checks = 0;
  int failures = 0;

  cmd_byte_assembler #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .ovr_err(ovr_err),
    .to_err(to_err), .send_resp(send_resp), .resp(resp), .trmt(trmt), .tx_data(tx_data),
    .tx_done(tx_done), .resp_sent(resp_sent)
  );

  always #5 clk = ~clk;

  // Model state: bytes of the half-built command, edge index of its high byte, response backlog.
  int          cyc = 0;
  int          hi_edge = 0;
  logic [7:0]  partial[$];
  logic [7:0]  pend[$];
  logic [7:0]  m_cur;
  bit          m_busy;
  bit          m_tx_known;
  logic [15:0] m_cmd;
  logic        m_cmd_rdy, m_ovr, m_to, m_trmt, m_resp_sent;
  logic [7:0]  m_tx_data;

  int          clr_cnt, to_cnt, rs_cnt, ovr_cnt;
  logic [7:0]  obs_tx[$];

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic startTx(input logic [7:0] b);
    m_cur      = b;
    m_tx_data  = b;
    m_trmt     = 1'b1;
    m_busy     = 1'b1;
    m_tx_known = 1'b1;
  endtask

  task automatic modelStep();
    logic prev_rdy;
    if (!rst_n) begin
      partial.delete();
      pend.delete();
      m_busy = 0; m_tx_known = 1; m_tx_data = 8'h00;
      m_cmd = 16'h0000; m_cmd_rdy = 0; m_ovr = 0; m_to = 0; m_trmt = 0; m_resp_sent = 0;
      return;
    end
    m_ovr = 0; m_to = 0; m_trmt = 0; m_resp_sent = 0;
    prev_rdy = m_cmd_rdy;
    if (clr_cmd_rdy) m_cmd_rdy = 0;
    if (partial.size() == 0) begin
      if (rx_rdy) begin
        partial.push_back(rx_data);
        hi_edge = cyc;
        m_cmd_rdy = 0;
      end
    end else if (rx_rdy) begin
      m_cmd = {partial[0], rx_data};
      m_ovr = prev_rdy && !clr_cmd_rdy;
      m_cmd_rdy = 1;
      partial.delete();
    end else if (cyc - hi_edge == TO) begin
      m_to = 1;
      partial.delete();
    end
    if (!m_busy) begin
      if (send_resp) startTx(resp);
    end else if (tx_done) begin
      m_resp_sent = 1;
      if (send_resp) begin
        pend.delete();
        startTx(resp);
      end else if (pend.size() != 0) begin
        startTx(pend.pop_front());
      end else begin
        m_busy = 0;
        m_tx_known = 0;
      end
    end else if (send_resp) begin
      pend.delete();
      pend.push_back(resp);
    end
  endtask

  task automatic checkAll();
    checkOutput("cmd", cmd, m_cmd);
    checkOutput("cmd_rdy", {15'd0, cmd_rdy}, {15'd0, m_cmd_rdy});
    checkOutput("ovr_err", {15'd0, ovr_err}, {15'd0, m_ovr});
    checkOutput("to_err", {15'd0, to_err}, {15'd0, m_to});
    checkOutput("trmt", {15'd0, trmt}, {15'd0, m_trmt});
    checkOutput("resp_sent", {15'd0, resp_sent}, {15'd0, m_resp_sent});
    if (m_tx_known) checkOutput("tx_data", {8'd0, tx_data}, {8'd0, m_tx_data});
  endtask

  // One clock cycle: drive inputs, check the combinational consume strobe, then the edge results.
  task automatic applyStimulus(input logic rr, input logic [7:0] rd, input logic cc,
                               input logic sr, input logic [7:0] rs, input logic td);
    rx_rdy = rr; rx_data = rd; clr_cmd_rdy = cc; send_resp = sr; resp = rs; tx_done = td;
    #1;
    checkOutput("clr_rx_rdy", {15'd0, clr_rx_rdy}, {15'd0, rr & rst_n});
    if (clr_rx_rdy === 1'b1) clr_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    modelStep();
    checkAll();
    if (trmt === 1'b1) obs_tx.push_back(tx_data);
    if (resp_sent === 1'b1) rs_cnt++;
    if (to_err === 1'b1) to_cnt++;
    if (ovr_err === 1'b1) ovr_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 8'h00, 0);
  endtask

  task automatic rxByte(input logic [7:0] b);
    applyStimulus(1, b, 0, 0, 8'h00, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 0);
    applyStimulus(1, 8'h99, 0, 1, 8'h77, 0);
    checkOutput("rst_cmd", cmd, 16'h0000);
    checkOutput("rst_tx_data", {8'd0, tx_data}, 16'h0000);
    rst_n = 1'b1;

    $display("[TB] two-byte command");
    clr_cnt = 0;
    rxByte(8'h29);
    idle(9);
    rxByte(8'h20);
    checkOutput("t1_cmd", cmd, 16'h2920);
    checkOutput("t1_cmd_rdy", {15'd0, cmd_rdy}, 16'h0001);
    idle(2);
    checkOutput("t1_clr_count", clr_cnt[15:0], 16'd2);
    applyStimulus(0, 8'h00, 1, 0, 8'h00, 0);
    checkOutput("t1_cleared", {15'd0, cmd_rdy}, 16'h0000);

    $display("[TB] inter-byte timeout");
    to_cnt = 0;
    rxByte(8'h40);
    idle(TO + 3);
    checkOutput("t2_to_count", to_cnt[15:0], 16'd1);
    rxByte(8'h12);
    rxByte(8'h34);
    checkOutput("t2_cmd", cmd, 16'h1234);
    rxByte(8'h55);
    idle(TO - 1);
    rxByte(8'h66);
    checkOutput("t2_last_cycle_byte", cmd, 16'h5566);

    $display("[TB] stale command and back-to-back commands");
    ovr_cnt = 0;
    rxByte(8'h29); rxByte(8'h20); idle(3);
    rxByte(8'h41);
    checkOutput("t3_invalidated", {15'd0, cmd_rdy}, 16'h0000);
    rxByte(8'h11);
    checkOutput("t3_cmd", cmd, 16'h4111);
    rxByte(8'hAA); rxByte(8'hBB); rxByte(8'hCC); rxByte(8'hDD);
    idle(2);
    checkOutput("t3_cmd2", cmd, 16'hCCDD);
    checkOutput("t3_ovr_count", ovr_cnt[15:0], 16'd0);
    rxByte(8'h01);
    applyStimulus(1, 8'h02, 1, 0, 8'h00, 0);
    checkOutput("t3_set_wins", {15'd0, cmd_rdy}, 16'h0001);

    $display("[TB] single response");
    obs_tx.delete(); rs_cnt = 0;
    applyStimulus(0, 8'h00, 0, 1, 8'hA5, 0);
    checkOutput("t4_trmt", {15'd0, trmt}, 16'h0001);
    checkOutput("t4_tx_data", {8'd0, tx_data}, 16'h00A5);
    idle(19);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1);
    checkOutput("t4_resp_sent", {15'd0, resp_sent}, 16'h0001);
    idle(2);

    $display("[TB] pending response overwrite");
    obs_tx.delete(); rs_cnt = 0;
    applyStimulus(0, 8'h00, 0, 1, 8'hA5, 0);
    idle(2);
    applyStimulus(0, 8'h00, 0, 1, 8'h5A, 0);
    applyStimulus(0, 8'h00, 0, 1, 8'h33, 0);
    idle(5);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1);
    idle(6);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1);
    idle(3);
    checkOutput("t5_tx_count", obs_tx.size(), 16'd2);
    if (obs_tx.size() == 2) begin
      checkOutput("t5_first", {8'd0, obs_tx[0]}, 16'h00A5);
      checkOutput("t5_second", {8'd0, obs_tx[1]}, 16'h0033);
    end
    checkOutput("t5_sent_count", rs_cnt[15:0], 16'd2);
    applyStimulus(0, 8'h00, 0, 1, 8'h10, 0);
    idle(2);
    applyStimulus(0, 8'h00, 0, 1, 8'h20, 0);
    applyStimulus(0, 8'h00, 0, 1, 8'h30, 1);
    checkOutput("t5_simul_tx", {8'd0, tx_data}, 16'h0030);
    idle(2);
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1);
    idle(2);

    $display("[TB] reset mid-transfer");
    rxByte(8'h77);
    applyStimulus(0, 8'h00, 0, 1, 8'h11, 0);
    applyStimulus(0, 8'h00, 0, 1, 8'h22, 0);
    rst_n = 1'b0;
    applyStimulus(1, 8'h55, 0, 0, 8'h00, 0);
    rst_n = 1'b1;
    checkOutput("t6_trmt", {15'd0, trmt}, 16'h0000);
    checkOutput("t6_cmd", cmd, 16'h0000);
    obs_tx.delete();
    applyStimulus(0, 8'h00, 0, 0, 8'h00, 1);
    idle(2);
    checkOutput("t6_no_pending_tx", obs_tx.size(), 16'd0);
    rxByte(8'hAB);
    rxByte(8'hCD);
    checkOutput("t6_cmd_after", cmd, 16'hABCD);

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      logic rr, cc, sr, td;
      bit slow;
      slow = ((i / 500) % 2) == 1;
      rr = slow ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 2) == 0);
      cc = ($urandom_range(0, 7) == 0);
      sr = ($urandom_range(0, 5) == 0);
      td = m_busy && ($urandom_range(0, 4) == 0);
      rst_n = (i % 997 == 500) ? 1'b0 : 1'b1;
      applyStimulus(rr, 8'($urandom), cc, sr, 8'($urandom), td);
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
